// File: rtl/hps_button_bridge_pkg.sv
// Shared constants for the HPS button bridge: clocking, debounce defaults and the
// bit positions of the button field inside the f2h/h2f general-purpose words.
package hps_button_bridge_pkg;

    localparam int CLOCK_HZ                = 50_000_000;
    localparam int DEFAULT_NUM_CHANNELS    = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;
    localparam int DEFAULT_DEBOUNCE_BITS   = 19;
    localparam int DEFAULT_COUNT_BITS      = 8;

    // Button field placement in f2h_value / h2f_value, shared by top-level packing and the driver.
    localparam int F2H_BUTTON_LSB   = 0;
    localparam int F2H_BUTTON_WIDTH = DEFAULT_NUM_CHANNELS;
    localparam int H2F_ACK_LSB      = 0;
    localparam int H2F_ACK_WIDTH    = DEFAULT_NUM_CHANNELS;

    function automatic int debounce_cycles_for_ms(input int ms);
        return (CLOCK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/hps_button_bridge_if.sv
// Signal bundle between the board keys / HPS registers (master) and the button bridge (slave).
interface hps_button_bridge_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_BITS   = 8
);

    logic [NUM_CHANNELS-1:0]            raw_button;
    logic [NUM_CHANNELS-1:0]            h2f_ack;
    logic [NUM_CHANNELS-1:0]            debounced;
    logic [NUM_CHANNELS-1:0]            f2h_state;
    logic [NUM_CHANNELS-1:0]            pending;
    logic [NUM_CHANNELS*COUNT_BITS-1:0] press_count;

    modport master (
        output raw_button, h2f_ack,
        input  debounced, f2h_state, pending, press_count
    );

    modport slave (
        input  raw_button, h2f_ack,
        output debounced, f2h_state, pending, press_count
    );

endinterface

// File: rtl/hps_button_bridge_channel.sv
// One button channel: polarity correction, two-flop synchroniser, stable-time debounce
// counter and a wrapping counter of debounced presses.
module button_debounce_channel
    import hps_button_bridge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DEBOUNCE_BITS   = DEFAULT_DEBOUNCE_BITS,
    parameter int COUNT_BITS      = DEFAULT_COUNT_BITS,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_raw,
    output logic                  o_debounced,
    output logic [COUNT_BITS-1:0] o_press_count
);

    localparam logic [DEBOUNCE_BITS-1:0] LAST_COUNT = DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);

    logic                     w_in;
    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_debounced;
    logic [DEBOUNCE_BITS-1:0] r_cnt;
    logic [COUNT_BITS-1:0]    r_press_count;

    assign w_in = i_raw ^ ACTIVE_LOW;

    // NOTE: reset clears the synchroniser too, so a key held through reset re-debounces from scratch.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_debounced   <= 1'b0;
            r_cnt         <= '0;
            r_press_count <= '0;
        end else begin
            // NOTE: non-blocking so r_sync2 takes the previous r_sync1, giving a true two-flop chain.
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_debounced) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST_COUNT) begin
                r_debounced <= r_sync2;
                r_cnt       <= '0;
                if (r_sync2) begin
                    r_press_count <= r_press_count + COUNT_BITS'(1);
                end
            end else begin
                r_cnt <= r_cnt + DEBOUNCE_BITS'(1);
            end
        end
    end

    assign o_debounced   = r_debounced;
    assign o_press_count = r_press_count;

endmodule

// File: rtl/hps_button_bridge.sv
// Multi-channel key-to-HPS bridge: per-channel debounce plus a level/acknowledge
// handshake that publishes the current debounced level whenever the HPS has caught up.
module hps_button_bridge
    import hps_button_bridge_pkg::*;
#(
    parameter int                        NUM_CHANNELS    = DEFAULT_NUM_CHANNELS,
    parameter int                        DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int                        DEBOUNCE_BITS   = DEFAULT_DEBOUNCE_BITS,
    parameter int                        COUNT_BITS      = DEFAULT_COUNT_BITS,
    parameter logic [NUM_CHANNELS-1:0]   ACTIVE_LOW_MASK = {NUM_CHANNELS{1'b1}}
) (
    input  logic               clock,
    input  logic               reset,
    hps_button_bridge_if.slave bus
);

    logic [NUM_CHANNELS-1:0] w_debounced;
    logic [NUM_CHANNELS-1:0] w_caught_up;
    logic [NUM_CHANNELS-1:0] r_f2h_state;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_channel
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DEBOUNCE_BITS   (DEBOUNCE_BITS),
            .COUNT_BITS      (COUNT_BITS),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[g])
        ) u_channel (
            .clock         (clock),
            .reset         (reset),
            .i_raw         (bus.raw_button[g]),
            .o_debounced   (w_debounced[g]),
            .o_press_count (bus.press_count[g*COUNT_BITS +: COUNT_BITS])
        );
    end

    // A channel may publish only once the HPS has echoed what it was last shown.
    assign w_caught_up = ~(r_f2h_state ^ bus.h2f_ack);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_f2h_state <= '0;
        end else begin
            r_f2h_state <= (r_f2h_state & ~w_caught_up) | (w_debounced & w_caught_up);
        end
    end

    assign bus.debounced = w_debounced;
    assign bus.f2h_state = r_f2h_state;
    assign bus.pending   = r_f2h_state ^ bus.h2f_ack;

endmodule
